multi_wave_generator: RTL and testbench

//  Parametrised successor to the counter/square/sawtooth chain: a phase accumulator

---
 rtl/wavegen_pkg.sv | 13 +
 rtl/wavegen_shaper.sv | 25 ++
 rtl/multi_wave_generator.sv | 88 ++++++++
 tb/tb_multi_wave_generator.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/wavegen_pkg.sv
// wavegen_pkg: waveform mode encodings and Q0.N_FRAC range helpers shared by the generator.
package wavegen_pkg;
  localparam logic [1:0] WAVE_SAW  = 2'd0;
  localparam logic [1:0] WAVE_RAMP = 2'd1;
  localparam logic [1:0] WAVE_TRI  = 2'd2;
  localparam logic [1:0] WAVE_SQR  = 2'd3;
  function automatic int max_val(input int n_frac);
    return (1 << n_frac) - 1;
  endfunction
  function automatic int min_val(input int n_frac);
    return -(1 << n_frac);
  endfunction
endpackage

// File: rtl/wavegen_shaper.sv
// wavegen_shaper: combinational map from accumulator phase to one of four signed waveforms.
module wavegen_shaper
  import wavegen_pkg::*;
#(
  parameter int N_FRAC = 7
) (
  input  logic signed [N_FRAC:0] acc_i,
  input  logic [1:0]             mode_i,
  input  logic signed [N_FRAC:0] thr_i,
  output logic signed [N_FRAC:0] shape_o
);
  localparam int W = N_FRAC + 1;
  localparam logic signed [W-1:0] MAX = W'(max_val(N_FRAC));
  localparam logic signed [W-1:0] MIN = W'(min_val(N_FRAC));
  logic [W-2:0] u;
  logic signed [W-1:0] tri_v;
  // Folding the negative half onto the positive one and forcing the LSB keeps the triangle odd-symmetric.
  assign u = acc_i[W-2:0] ^ {(W-1){acc_i[W-1]}};
  assign tri_v = {u, 1'b1} ^ {1'b1, {(W-1){1'b0}}};
  always_comb
    shape_o = (mode_i == WAVE_SAW)  ? acc_i :
              (mode_i == WAVE_RAMP) ? ((acc_i == MIN) ? MAX : -acc_i) :
              (mode_i == WAVE_TRI)  ? tri_v :
              ((acc_i < thr_i) ? MAX : -MAX);
endmodule

// File: rtl/multi_wave_generator.sv
// multi_wave_generator: phase accumulator, waveform shaper and saturating amplitude scaler, 2-cycle latency.
// Define WAVEGEN_DUTY_EN to add the duty_i square-wave threshold port (otherwise threshold is 0).
module multi_wave_generator
  import wavegen_pkg::*;
#(
  parameter int N_FRAC = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic signed [N_FRAC:0] phase_i,
  input  logic signed [N_FRAC:0] amplitude_i,
  input  logic [1:0]             mode_i,
  input  logic                   next_data_strobe_i,
`ifdef WAVEGEN_DUTY_EN
  input  logic signed [N_FRAC:0] duty_i,
`endif
  output logic signed [N_FRAC:0] data_o,
  output logic                   data_valid_strobe_o,
  output logic                   wrap_o
);
  localparam int W = N_FRAC + 1;
  localparam logic signed [W-1:0] MAX = W'(max_val(N_FRAC));
  localparam logic signed [W-1:0] MIN = W'(min_val(N_FRAC));
  localparam logic signed [2*W-1:0] HI = (2*W)'(max_val(N_FRAC));
  localparam logic signed [2*W-1:0] LO = (2*W)'(min_val(N_FRAC));
  logic signed [W-1:0] acc_q, acc_d, amp1_q, thr1_q, shape_q, shape_d, amp2_q, data_q, data_d, thr_in;
  logic [1:0] mode1_q;
  logic v1_q, v2_q, valid_q, wrap1_q, wrap2_q, wrap_q, cap, ovf;
  logic [W:0] sum;
  logic signed [2*W-1:0] prod, scaled;
`ifdef WAVEGEN_DUTY_EN
  assign thr_in = duty_i;
`else
  assign thr_in = '0;
`endif
  // Clear dominates a coincident strobe so the first post-clear sample starts exactly from 0.
  always_comb begin
    cap = next_data_strobe_i & ~clear_i;
    sum = {acc_q[W-1], acc_q} + {phase_i[W-1], phase_i};
    ovf = sum[W] ^ sum[W-1];
    acc_d = clear_i ? '0 : cap ? sum[W-1:0] : acc_q;
    prod = shape_q * amp2_q;
    scaled = prod >>> N_FRAC;
    data_d = (scaled > HI) ? MAX : (scaled < LO) ? MIN : scaled[W-1:0];
  end
  wavegen_shaper #(.N_FRAC(N_FRAC)) u_shaper (
    .acc_i  (acc_q),
    .mode_i (mode1_q),
    .thr_i  (thr1_q),
    .shape_o(shape_d)
  );
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      acc_q   <= '0;
      v1_q    <= 1'b0;
      wrap1_q <= 1'b0;
      mode1_q <= '0;
      amp1_q  <= '0;
      thr1_q  <= '0;
      shape_q <= '0;
      amp2_q  <= '0;
      v2_q    <= 1'b0;
      wrap2_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      v1_q    <= cap;
      if (cap) begin
        wrap1_q <= ovf;
        mode1_q <= mode_i;
        amp1_q  <= amplitude_i;
        thr1_q  <= thr_in;
      end
      shape_q <= shape_d;
      amp2_q  <= amp1_q;
      wrap2_q <= wrap1_q;
      v2_q    <= v1_q & ~clear_i;
      if (v2_q && !clear_i) data_q <= data_d;
      valid_q <= v2_q & ~clear_i;
      wrap_q  <= v2_q & ~clear_i & wrap2_q;
    end
  assign data_o = data_q;
  assign data_valid_strobe_o = valid_q;
  assign wrap_o = wrap_q;
endmodule

// File: tb/tb_multi_wave_generator.sv
// tb_multi_wave_generator: scoreboard bench; an arithmetic reference model queues expected samples, a monitor pops them.
module tb_multi_wave_generator;
  import wavegen_pkg::*;
  localparam int NF = 7;
  localparam int M = (1 << NF) - 1;
  typedef struct { int data; bit wrap; int due; } exp_t;
  logic clk_i = 1'b0, rst_i = 1'b0, clear_i = 1'b0, stb = 1'b0;
  logic signed [NF:0] phase = '0, amp = '0, duty = '0;
  logic [1:0] mode = '0;
  logic signed [NF:0] data_o;
  logic valid, wrap;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0, acc_m = 0, last = 0;

  multi_wave_generator #(.N_FRAC(NF)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .clear_i            (clear_i),
    .phase_i            (phase),
    .amplitude_i        (amp),
    .mode_i             (mode),
    .next_data_strobe_i (stb),
`ifdef WAVEGEN_DUTY_EN
    .duty_i             (duty),
`endif
    .data_o             (data_o),
    .data_valid_strobe_o(valid),
    .wrap_o             (wrap)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic int shape_m(input int a, input int md, input int thr);
    if (md == 0) return a;
    if (md == 1) return (a == -M - 1) ? M : -a;
    if (md == 2) return (a >= 0) ? 2 * a - M : -2 * a - M - 2;
    return (a < thr) ? M : -M;
  endfunction

  function automatic int scale_m(input int s, input int g);
    int p;
    p = (s * g) >>> NF;
    return (p > M) ? M : p;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic drive(input bit s, input bit c, input int ph, input int g, input int md, input int du);
    int edge_no, sum, thr;
    bit w;
    @(posedge clk_i);
    #1;
    stb = s; clear_i = c; phase = 8'(ph); amp = 8'(g); mode = 2'(md); duty = 8'(du);
    edge_no = cyc + 1;
    if (c) begin
      acc_m = 0;
      while (q.size() > 0 && q[$].due >= edge_no) void'(q.pop_back());
    end else if (s) begin
      sum = acc_m + ph;
      w = (sum > M) || (sum < -M - 1);
      acc_m = (sum > M) ? sum - 2 * (M + 1) : (sum < -M - 1) ? sum + 2 * (M + 1) : sum;
`ifdef WAVEGEN_DUTY_EN
      thr = du;
`else
      thr = 0;
`endif
      q.push_back('{scale_m(shape_m(acc_m, md, thr), g), w, edge_no + 2});
    end
  endtask

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i) last = 0;
    else if (valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid at=%0d data=%0d", cyc, data_o);
      end else begin
        e = q.pop_front();
        if (int'(data_o) != e.data || wrap != e.wrap || cyc != e.due) begin
          errors++;
          $display("FAIL sample at=%0d due=%0d data=%0d required=%0d wrap=%0d required=%0d",
                   cyc, e.due, data_o, e.data, wrap, e.wrap);
        end
      end
      last = int'(data_o);
    end else begin
      checks++;
      if (int'(data_o) != last) begin
        errors++;
        $display("FAIL hold at=%0d data=%0d required=%0d", cyc, data_o, last);
      end
      if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_valid at=%0d due=%0d required_data=%0d", cyc, e.due, e.data);
      end
    end
  end

  initial begin
    #12;
    chk("reset_data", int'(data_o), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_wrap", int'(wrap), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 20; i++) drive(1, 0, 16, 127, WAVE_SAW, 0);
    for (int i = 0; i < 24; i++) drive(1, 0, 32, 127, WAVE_TRI, 0);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(1, 0, 64, -128, WAVE_SQR, 0);
    for (int i = 0; i < 8; i++) drive(1, 0, 64, 127, WAVE_SQR, 64);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, -128, -128, WAVE_RAMP, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, -128, -128, WAVE_SAW, 0);
    drive(1, 0, 0, -128, WAVE_TRI, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 77, WAVE_SAW, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, i == 4, 16, 127, WAVE_SAW, 0);
    for (int i = 0; i < 300; i++)
      drive($urandom_range(3) != 0, $urandom_range(19) == 0, rnd8(), rnd8(),
            int'($urandom_range(3)), rnd8());
    for (int i = 0; i < 5; i++) drive(1, 0, 16, 127, WAVE_TRI, 0);
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
    chk("async_reset_data", int'(data_o), 0);
    chk("async_reset_valid", int'(valid), 0);
    chk("async_reset_wrap", int'(wrap), 0);
    q.delete();
    acc_m = 0;
    stb = 1'b0;
    clear_i = 1'b0;
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) drive(1, 0, 16, 127, WAVE_SAW, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
